// File: rtl/struct_rec_assembler.sv
// Gathers NUM_SUB consecutive sub_struct_t beats into one packed record and
// hands it downstream over a valid/ready port. Field 0 sits in the MSBs.
module struct_rec_assembler #(
  parameter int NUM_SUB = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic [1:0]           in_beat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NUM_SUB-1:0] out_rec,
  output logic                 out_first_a,
  output logic                 out_last_b,
  output logic [CNT_W-1:0]     rec_count,
  output logic [CNT_W-1:0]     drop_count
);

  localparam int REC_W = 2 * NUM_SUB;
  localparam int IDX_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;

  typedef struct packed {
    logic a;
    logic b;
  } sub_sub_struct_t;

  typedef struct packed {
    sub_sub_struct_t c;
  } sub_struct_t;

  typedef sub_struct_t [NUM_SUB-1:0] rec_t;

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  rec_t             rec, rec_n;
  logic             accept, drop_inc, deliver;

  // Field k lives at struct index NUM_SUB-1-k, i.e. bit offset 2*(NUM_SUB-1-k).
  function automatic rec_t put_field(input rec_t r, input int unsigned pos,
                                     input logic [1:0] beat);
    logic [REC_W-1:0] flat;
    int unsigned      sh;
    sh   = 2 * (NUM_SUB - 1 - pos);
    flat = r;
    flat = (flat & ~(REC_W'(2'b11) << sh)) | (REC_W'(beat) << sh);
    return rec_t'(flat);
  endfunction

  assign in_ready = (state != FULL) | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rec_n    = rec;
    drop_inc = 1'b0;
    deliver  = 1'b0;
    case (state)
      IDLE, FULL: begin
        if (state == FULL) begin
          deliver = out_ready;
          if (out_ready) state_n = IDLE;
        end
        // In FULL a beat is only accepted alongside the handoff, so the
        // record register is free to start the next record in the same cycle.
        if (accept) begin
          if (in_sop) begin
            rec_n   = put_field(rec, 0, in_beat);
            idx_n   = IDX_W'(1);
            state_n = (NUM_SUB == 1) ? FULL : COLLECT;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (in_sop) begin
            drop_inc = 1'b1;
            rec_n    = put_field(rec, 0, in_beat);
            idx_n    = IDX_W'(1);
          end else begin
            rec_n = put_field(rec, 32'(idx), in_beat);
            if (32'(idx) == NUM_SUB - 1) begin
              state_n = FULL;
              idx_n   = '0;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rec        <= '0;
      rec_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rec   <= rec_n;
      if (deliver) rec_count <= rec_count + 1'b1;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  assign out_valid   = (state == FULL);
  assign out_rec     = rec;
  assign out_first_a = rec[NUM_SUB-1].c.a;
  assign out_last_b  = rec[0].c.b;

endmodule

// File: tb/tb_struct_rec_assembler.sv
// Scoreboard bench for struct_rec_assembler (NUM_SUB=2, CNT_W=8).
module tb_struct_rec_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sop;
  logic [1:0] in_beat;
  logic       out_valid, out_ready;
  logic [3:0] out_rec;
  logic       out_first_a, out_last_b;
  logic [7:0] rec_count, drop_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] sb[$];
  logic [3:0] mon_exp;
  logic [7:0] exp_rc = '0;

  struct_rec_assembler #(.NUM_SUB(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_beat(in_beat),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_first_a(out_first_a), .out_last_b(out_last_b),
    .rec_count(rec_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Handoff happens on the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst) begin
      exp_rc = '0;
    end else if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got=%b required=none", out_rec);
      end else begin
        mon_exp = sb.pop_front();
        if (out_rec !== mon_exp || out_first_a !== mon_exp[3] || out_last_b !== mon_exp[0]) begin
          errors++;
          $display("FAIL record got=%b a=%b b=%b required=%b a=%b b=%b",
                   out_rec, out_first_a, out_last_b, mon_exp, mon_exp[3], mon_exp[0]);
        end
      end
      exp_rc = exp_rc + 8'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic sop, input logic [1:0] beat);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_beat  = beat;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_beat = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release rdy=%b vld=%b rec=%b required 1 0 0000", in_ready, out_valid, out_rec);
    end
    send_beat(1'b0, 2'b01);
    send_beat(1'b1, 2'b11);
    send_beat(1'b0, 2'b10);
    checks++;
    if (out_valid !== 1'b1 || out_rec !== 4'b1110 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset vld=%b rec=%b drop=%0d required 1 1110 1", out_valid, out_rec, drop_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rec !== 4'b0000 || drop_count !== 8'd0 || rec_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset vld=%b rec=%b drop=%0d cnt=%0d required 0 0000 0 0",
               out_valid, out_rec, drop_count, rec_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset got=%b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(1'b1, 2'b11);
    sb.push_back(4'b1100);
    send_beat(1'b0, 2'b00);
    checks++;
    if (out_valid !== 1'b1 || out_rec !== 4'b1100 || out_first_a !== 1'b1 || out_last_b !== 1'b0) begin
      errors++;
      $display("FAIL basic_out vld=%b rec=%b a=%b b=%b required 1 1100 1 0",
               out_valid, out_rec, out_first_a, out_last_b);
    end
    @(posedge clk); #1;
    checks++;
    if (rec_count !== 8'd1 || rec_count !== exp_rc || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_count cnt=%0d vld=%b required 1 0", rec_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(1'b1, 2'b10);
    send_beat(1'b0, 2'b01);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold vld=%b rdy=%b required 1 0", out_valid, in_ready);
    end
    in_valid = 1'b1; in_sop = 1'b1; in_beat = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_rec !== 4'b1001 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stable cycle=%0d rec=%b rdy=%b vld=%b required 1001 0 1",
                 i, out_rec, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    sb.push_back(4'b1001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || rec_count !== 8'd2 || drop_count !== 8'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_release vld=%b cnt=%0d drop=%0d pending=%0d required 0 2 0 0",
               out_valid, rec_count, drop_count, sb.size());
    end
  endtask

  task automatic test_drop();
    out_ready = 1'b1;
    send_beat(1'b1, 2'b01);
    send_beat(1'b1, 2'b10);
    sb.push_back(4'b1011);
    send_beat(1'b0, 2'b11);
    @(posedge clk); #1;
    checks++;
    if (drop_count !== 8'd1 || rec_count !== 8'd3 || sb.size() != 0) begin
      errors++;
      $display("FAIL drop_partial drop=%0d cnt=%0d pending=%0d required 1 3 0",
               drop_count, rec_count, sb.size());
    end
    for (int i = 0; i < 300; i++) send_beat(1'b0, 2'($urandom));
    checks++;
    if (drop_count !== 8'd255 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_saturate drop=%0d vld=%b required 255 0", drop_count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] b0, b1;
    int         start;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 300; i++) begin
      b0 = 2'($urandom);
      b1 = 2'($urandom);
      sb.push_back({b0, b1});
      send_beat(1'b1, b0);
      send_beat(1'b0, b1);
    end
    checks++;
    if (cyc - start != 600) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d required=600", cyc - start);
    end
    @(posedge clk); #1;
    checks++;
    if (rec_count !== 8'd44 || rec_count !== exp_rc || drop_count !== 8'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count cnt=%0d drop=%0d pending=%0d required 44 0 0",
               rec_count, drop_count, sb.size());
    end
  endtask

  task automatic test_reset_collect();
    out_ready = 1'b1;
    send_beat(1'b1, 2'b10);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rec_count !== 8'd0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_collect vld=%b cnt=%0d drop=%0d required 0 0 0", out_valid, rec_count, drop_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    send_beat(1'b1, 2'b01);
    sb.push_back(4'b0110);
    send_beat(1'b0, 2'b10);
    checks++;
    if (out_valid !== 1'b1 || out_rec !== 4'b0110) begin
      errors++;
      $display("FAIL post_rst_rec vld=%b rec=%b required 1 0110", out_valid, out_rec);
    end
    @(posedge clk); #1;
    checks++;
    if (rec_count !== 8'd1 || drop_count !== 8'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_rst_count cnt=%0d drop=%0d pending=%0d required 1 0 0",
               rec_count, drop_count, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_collect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
